// File: rtl/gun_pkg.sv
// Shared types and constants for the light-gun H/V position latch.
package gun_pkg;

    localparam int FILTER_LEN_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        QUAL = 2'd2,
        HELD = 2'd3
    } gun_state_t;

endpackage

// File: rtl/gun_sync.sv
// Two-flop synchronizer bringing the asynchronous gun sensor into the clock domain.
module gun_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/gun_hv_latch.sv
// Light-gun H/V position latch: one latch per frame, sticky flag cleared by status read.
// Define GUN_LATCH_FILTER_EN to require FILTER_LEN consecutive lit samples before committing.
module gun_hv_latch
    import gun_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ce_pix,
    input  logic [9:0] i_hcnt,
    input  logic [8:0] i_vcnt,
    input  logic       i_vblank,
    input  logic       i_exlten,
    input  logic       i_sensor,
    input  logic       i_rd_stb,
    output logic [9:0] o_latch_h,
    output logic [8:0] o_latch_v,
    output logic       o_exltfg,
    output logic       o_overrun,
    output logic       o_latch_irq
);

    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_badFilterLen
        $error("gun_hv_latch: FILTER_LEN must be within 1..15");
    end

    gun_state_t r_state;
    gun_state_t w_nextState;

    logic       w_sensor;
    logic       r_sensPrev;
    logic       r_vblankPrev;
    logic       w_edge;
    logic       w_vblankRise;
    logic       w_commit;
    logic [9:0] w_commitH;
    logic [8:0] w_commitV;

    logic [9:0] r_latchH;
    logic [8:0] r_latchV;
    logic       r_exltfg;
    logic       r_overrun;
    logic       r_irq;

`ifdef GUN_LATCH_FILTER_EN
    localparam logic [3:0] FILTER_LEN_C = 4'(FILTER_LEN);

    logic [3:0] r_qualCount;
    logic [3:0] w_nextCount;
    logic [9:0] r_candH;
    logic [8:0] r_candV;
    logic       w_capture;
`endif

    gun_sync u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_sensor),
        .o_sync  (w_sensor)
    );

    assign w_edge       = i_ce_pix & w_sensor & ~r_sensPrev;
    assign w_vblankRise = i_vblank & ~r_vblankPrev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_commit    = 1'b0;
        w_commitH   = i_hcnt;
        w_commitV   = i_vcnt;
`ifdef GUN_LATCH_FILTER_EN
        w_nextCount = r_qualCount;
        w_capture   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (i_exlten) w_nextState = ARM;
            end
            ARM: begin
                if (w_edge) begin
`ifdef GUN_LATCH_FILTER_EN
                    if (FILTER_LEN_C == 4'd1) begin
                        w_commit    = 1'b1;
                        w_nextState = HELD;
                    end else begin
                        w_capture   = 1'b1;
                        w_nextCount = 4'd1;
                        w_nextState = QUAL;
                    end
`else
                    w_commit    = 1'b1;
                    w_nextState = HELD;
`endif
                end
            end
`ifdef GUN_LATCH_FILTER_EN
            // Latched position is where the light first appeared, not where it qualified.
            QUAL: begin
                if (i_ce_pix) begin
                    if (!w_sensor) begin
                        w_nextState = ARM;
                    end else if (r_qualCount + 4'd1 == FILTER_LEN_C) begin
                        w_commit    = 1'b1;
                        w_commitH   = r_candH;
                        w_commitV   = r_candV;
                        w_nextState = HELD;
                    end else begin
                        w_nextCount = r_qualCount + 4'd1;
                    end
                end
            end
`endif
            HELD: begin
                if (w_vblankRise) w_nextState = ARM;
            end
            default: w_nextState = IDLE;
        endcase
        if (!i_exlten) begin
            w_nextState = IDLE;
            w_commit    = 1'b0;
`ifdef GUN_LATCH_FILTER_EN
            w_capture   = 1'b0;
`endif
        end
    end

    // A read landing on the same cycle as a commit acknowledges the older latch only.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sensPrev   <= 1'b0;
            r_vblankPrev <= 1'b0;
            r_latchH     <= '0;
            r_latchV     <= '0;
            r_exltfg     <= 1'b0;
            r_overrun    <= 1'b0;
            r_irq        <= 1'b0;
`ifdef GUN_LATCH_FILTER_EN
            r_qualCount  <= '0;
            r_candH      <= '0;
            r_candV      <= '0;
`endif
        end else begin
            r_vblankPrev <= i_vblank;
            r_irq        <= w_commit;
            if (i_ce_pix) r_sensPrev <= w_sensor;
`ifdef GUN_LATCH_FILTER_EN
            r_qualCount <= w_nextCount;
            if (w_capture) begin
                r_candH <= i_hcnt;
                r_candV <= i_vcnt;
            end
`endif
            if (w_commit) begin
                r_latchH  <= w_commitH;
                r_latchV  <= w_commitV;
                r_exltfg  <= 1'b1;
                r_overrun <= ~i_rd_stb & (r_exltfg | r_overrun);
            end else if (i_rd_stb) begin
                r_exltfg  <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_latch_h   = r_latchH;
    assign o_latch_v   = r_latchV;
    assign o_exltfg    = r_exltfg;
    assign o_overrun   = r_overrun;
    assign o_latch_irq = r_irq;

endmodule

// File: doc/gun_hv_latch.md
GUN_HV_LATCH -- requirements
Module: gun_hv_latch

Interface
REQ-001 Parameter FILTER_LEN, default 3, consecutive high CE_PIX samples required to qualify a sensor pulse (range 1-15).
REQ-002 CLK  in  1  system clock; all logic on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 CE_PIX  in  1  dot-clock enable; sampling and qualification advance only when high.
REQ-005 HCNT  in  10  current horizontal dot counter.
REQ-006 VCNT  in  9  current vertical line counter.
REQ-007 VBLANK  in  1  vertical blanking, active-high.
REQ-008 EXLTEN  in  1  external latch enable from VDP register.
REQ-009 SENSOR  in  1  asynchronous gun-port light sensor, active-high.
REQ-010 RD_STB  in  1  one-CLK status-read strobe; clears EXLTFG and OVERRUN.
REQ-011 LATCH_H  out  10  latched horizontal position.
REQ-012 LATCH_V  out  9  latched vertical position.
REQ-013 EXLTFG  out  1  latch-valid flag, sticky until read.
REQ-014 OVERRUN  out  1  a second latch committed while EXLTFG was already set.
REQ-015 LATCH_IRQ  out  1  one-CLK pulse on every commit.

Function
REQ-016 SENSOR shall pass through a two-flop synchronizer on CLK before any use.
REQ-017 The FSM shall have states IDLE, ARM, QUAL, HELD.
REQ-018 IDLE: entered whenever EXLTEN=0 (from any state, next CLK); exits to ARM when EXLTEN=1.
REQ-019 ARM: on a CE_PIX sample with synced sensor 1 and previous sample 0, capture HCNT/VCNT into a candidate register, set qual count to 1, go to QUAL (or commit immediately if FILTER_LEN=1).
REQ-020 QUAL: each CE_PIX sample with sensor 1 increments count; when count reaches FILTER_LEN, commit the candidate and go to HELD; a CE_PIX sample with sensor 0 discards the candidate and returns to ARM.
REQ-021 Commit: LATCH_H/LATCH_V take the candidate values (first-edge position, not qualification position), EXLTFG<=1, LATCH_IRQ pulses for exactly one CLK.
REQ-022 Commit while EXLTFG=1 and no RD_STB that cycle shall set OVERRUN and overwrite LATCH_H/LATCH_V.
REQ-023 HELD: further pulses ignored; rising edge of VBLANK (CLK-sampled) returns to ARM, one latch per frame.
REQ-024 RD_STB and commit in the same CLK: EXLTFG stays 1, OVERRUN cleared.
REQ-025 RD_STB alone clears EXLTFG and OVERRUN next CLK; LATCH_H/LATCH_V retain values.
REQ-026 A VBLANK rising edge during QUAL shall not abort qualification.
REQ-027 Latency: commit visible on outputs one CLK after the qualifying CE_PIX sample; total input-to-commit >= 2 CLK synchronizer + FILTER_LEN CE_PIX samples.

Reset
REQ-028 On RESET: state IDLE, LATCH_H=0, LATCH_V=0, EXLTFG=0, OVERRUN=0, LATCH_IRQ=0, synchronizer and qual count cleared; reset mid-QUAL discards the candidate.

Configuration
REQ-029 Macro GUN_LATCH_FILTER_EN defined: QUAL state and FILTER_LEN behave per REQ-020.
REQ-030 Macro GUN_LATCH_FILTER_EN undefined: QUAL state removed; commit on the first synced rising-edge CE_PIX sample in ARM; FILTER_LEN ignored.

Structure
REQ-031 Package gun_pkg shall hold the FSM state enum and the FILTER_LEN default constant.
REQ-032 The two-flop synchronizer shall be a sub-module named gun_sync; all else in gun_hv_latch.

Verification
REQ-033 EXLTEN=1, SENSOR high 5 CE_PIX starting at HCNT=100,VCNT=50, FILTER_LEN=3 -> LATCH_H=100, LATCH_V=50, EXLTFG=1, one LATCH_IRQ pulse.
REQ-034 SENSOR high 2 CE_PIX only, FILTER_LEN=3 -> no commit, EXLTFG=0, state ARM.
REQ-035 Valid pulse at HCNT=200, second pulse same frame at HCNT=300 -> LATCH_H stays 200; after VBLANK rise, pulse at HCNT=300 with no read -> LATCH_H=300, OVERRUN=1.
REQ-036 RD_STB coincident with commit -> EXLTFG=1, OVERRUN=0; RD_STB alone next -> EXLTFG=0.
REQ-037 EXLTEN dropped mid-QUAL, or RESET mid-QUAL -> no commit, all outputs at reset values (RESET case).
REQ-038 Build without GUN_LATCH_FILTER_EN, single-sample pulse at HCNT=7 -> LATCH_H=7, EXLTFG=1.
